// File: rtl/multicycle_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl_pkg
//   Shared types and encodings for the multicycle MIPS control unit:
//   FSM state enum, opcode/func constants, datapath mux encodings, the
//   decoded instruction class and the bundle of control outputs.
// ----------------------------------------------------------------------------
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] FUNC_NOP = 6'h00;

    localparam logic [1:0] PC_SRC_SEQ = 2'd0;  // PC+4
    localparam logic [1:0] PC_SRC_BR  = 2'd1;  // branch target
    localparam logic [1:0] PC_SRC_JMP = 2'd2;  // jump target

    localparam logic [1:0] ALUB_RT   = 2'd0;
    localparam logic [1:0] ALUB_SIMM = 2'd1;
    localparam logic [1:0] ALUB_ZIMM = 2'd2;

    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_SUB  = 2'd1;
    localparam logic [1:0] ALU_FUNC = 2'd2;
    localparam logic [1:0] ALU_OR   = 2'd3;

    localparam logic [1:0] DST_RT  = 2'd0;
    localparam logic [1:0] DST_RD  = 2'd1;
    localparam logic [1:0] DST_R31 = 2'd2;

    typedef enum logic [3:0] {
        IC_ILLEGAL, IC_NOP, IC_R, IC_J, IC_JAL,
        IC_BEQ, IC_BNE, IC_ADDI, IC_ORI, IC_LW, IC_SW
    } iclass_t;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       dmem_we;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic       mem_to_reg;
        logic       link;
        logic       illegal;
        logic       instr_done;
    } ctl_t;

endpackage

// File: rtl/mc_decode.sv
// ----------------------------------------------------------------------------
// mc_decode
//   Pure combinational opcode/func -> instruction class decode.
//   Ports:
//     op     in  OPW    opcode field of IR
//     func   in  FUNCW  R-type func field of IR
//     iclass out        decoded instruction class (IC_ILLEGAL if unknown)
// ----------------------------------------------------------------------------
module mc_decode
    import multicycle_ctrl_pkg::*;
#(
    parameter int OPW   = 6,
    parameter int FUNCW = 6
) (
    input  logic [OPW-1:0]   op,
    input  logic [FUNCW-1:0] func,
    output iclass_t          iclass
);

    always_comb begin
        iclass = IC_ILLEGAL;
        case (op)
            OPW'(OP_R):    iclass = (func == FUNCW'(FUNC_NOP)) ? IC_NOP : IC_R;
            OPW'(OP_J):    iclass = IC_J;
            OPW'(OP_JAL):  iclass = IC_JAL;
            OPW'(OP_BEQ):  iclass = IC_BEQ;
            OPW'(OP_BNE):  iclass = IC_BNE;
            OPW'(OP_ADDI): iclass = IC_ADDI;
            OPW'(OP_ORI):  iclass = IC_ORI;
            OPW'(OP_LW):   iclass = IC_LW;
            OPW'(OP_SW):   iclass = IC_SW;
            default:       iclass = IC_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl
//   Multicycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with
//   req/ack memory handshakes and a global stall. Outputs are decoded from
//   the current state; write strobes are qualified by acks and by stall.
//   Optional feature macro: MC_PERF_CNT_EN adds cyc_cnt / ret_cnt outputs.
//   Ports:
//     clk, reset (async, active-high)
//     op, func, alu_zero         decode fields / ALU flag
//     stall                      freezes FSM, masks write strobes
//     imem_req/imem_ack          instruction fetch handshake
//     dmem_req/dmem_we/dmem_ack  data memory handshake
//     ir_we, pc_we, pc_src, alu_src_b, alu_op, reg_we, reg_dst,
//     mem_to_reg, link           datapath controls
//     illegal, instr_done        status pulses
//     state_o                    current FSM state
//     cyc_cnt, ret_cnt           perf counters (MC_PERF_CNT_EN only)
// ----------------------------------------------------------------------------
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int OPW   = 6,
    parameter int FUNCW = 6,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPW-1:0]   op,
    input  logic [FUNCW-1:0] func,
    input  logic             alu_zero,
    input  logic             stall,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_we,
    output logic [1:0]       reg_dst,
    output logic             mem_to_reg,
    output logic             link,
    output logic             illegal,
    output logic             instr_done,
`ifdef MC_PERF_CNT_EN
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
`endif
    output logic [2:0]       state_o
);

    state_t  state, state_nx;
    iclass_t iclass;
    ctl_t    ctl;

    mc_decode #(.OPW(OPW), .FUNCW(FUNCW)) u_decode (
        .op     (op),
        .func   (func),
        .iclass (iclass)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nx;
    end

    always_comb begin
        ctl      = '0;
        state_nx = state;
        case (state)
            S_FETCH: begin
                ctl.imem_req = 1'b1;
                if (imem_ack) begin
                    ctl.ir_we  = 1'b1;
                    ctl.pc_we  = 1'b1;
                    ctl.pc_src = PC_SRC_SEQ;
                    state_nx   = S_DECODE;
                end
            end
            S_DECODE: begin
                case (iclass)
                    IC_J, IC_JAL: begin
                        ctl.pc_we      = 1'b1;
                        ctl.pc_src     = PC_SRC_JMP;
                        ctl.instr_done = 1'b1;
                        if (iclass == IC_JAL) begin
                            ctl.reg_we  = 1'b1;
                            ctl.reg_dst = DST_R31;
                            ctl.link    = 1'b1;
                        end
                        state_nx = S_FETCH;
                    end
                    IC_NOP: begin
                        ctl.instr_done = 1'b1;
                        state_nx       = S_FETCH;
                    end
                    IC_ILLEGAL: begin
                        ctl.illegal = 1'b1;
                        state_nx    = S_FETCH;
                    end
                    default: state_nx = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (iclass)
                    IC_BEQ, IC_BNE: begin
                        ctl.alu_op     = ALU_SUB;
                        ctl.pc_src     = PC_SRC_BR;
                        // BNE takes the branch when the difference is non-zero
                        ctl.pc_we      = alu_zero ^ (iclass == IC_BNE);
                        ctl.instr_done = 1'b1;
                        state_nx       = S_FETCH;
                    end
                    IC_R: begin
                        ctl.alu_op = ALU_FUNC;
                        state_nx   = S_WB;
                    end
                    IC_ADDI: begin
                        ctl.alu_src_b = ALUB_SIMM;
                        ctl.alu_op    = ALU_ADD;
                        state_nx      = S_WB;
                    end
                    IC_ORI: begin
                        ctl.alu_src_b = ALUB_ZIMM;
                        ctl.alu_op    = ALU_OR;
                        state_nx      = S_WB;
                    end
                    IC_LW, IC_SW: begin
                        ctl.alu_src_b = ALUB_SIMM;
                        ctl.alu_op    = ALU_ADD;
                        state_nx      = S_MEM;
                    end
                    default: state_nx = S_FETCH;  // IR changed under us; recover
                endcase
            end
            S_MEM: begin
                ctl.dmem_req = 1'b1;
                ctl.dmem_we  = (iclass == IC_SW);
                if (dmem_ack) begin
                    if (iclass == IC_SW) begin
                        ctl.instr_done = 1'b1;
                        state_nx       = S_FETCH;
                    end else begin
                        state_nx = S_WB;
                    end
                end
            end
            S_WB: begin
                ctl.reg_we     = 1'b1;
                ctl.reg_dst    = (iclass == IC_R) ? DST_RD : DST_RT;
                ctl.mem_to_reg = (iclass == IC_LW);
                ctl.instr_done = 1'b1;
                state_nx       = S_FETCH;
            end
            default: state_nx = S_FETCH;
        endcase

        // Stall freezes the FSM; req lines are state-decoded so they hold.
        if (stall) begin
            state_nx       = state;
            ctl.ir_we      = 1'b0;
            ctl.pc_we      = 1'b0;
            ctl.reg_we     = 1'b0;
            ctl.illegal    = 1'b0;
            ctl.instr_done = 1'b0;
        end

        // Async reset must silence every output in the reset cycle itself.
        if (reset) ctl = '0;
    end

    assign imem_req   = ctl.imem_req;
    assign dmem_req   = ctl.dmem_req;
    assign dmem_we    = ctl.dmem_we;
    assign ir_we      = ctl.ir_we;
    assign pc_we      = ctl.pc_we;
    assign pc_src     = ctl.pc_src;
    assign alu_src_b  = ctl.alu_src_b;
    assign alu_op     = ctl.alu_op;
    assign reg_we     = ctl.reg_we;
    assign reg_dst    = ctl.reg_dst;
    assign mem_to_reg = ctl.mem_to_reg;
    assign link       = ctl.link;
    assign illegal    = ctl.illegal;
    assign instr_done = ctl.instr_done;
    assign state_o    = state;

`ifdef MC_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_cnt <= '0;
            ret_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
            if (ctl.instr_done) ret_cnt <= ret_cnt + CNT_W'(1);
        end
    end
`else
    // CNT_W only sizes the perf counters; keep it referenced when they are absent.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Directed self-checking bench for multicycle_ctrl. Inputs change on the
//   falling edge; outputs are compared 1 time unit later, well before the
//   next rising edge. Every cycle compares the full control bundle + state.
// ----------------------------------------------------------------------------
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    logic       clk = 1'b0, reset = 1'b1;
    logic [5:0] op = '0, func = '0;
    logic       alu_zero = 1'b0, stall = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
    logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we;
    logic       mem_to_reg, link, illegal, instr_done;
    logic [1:0] pc_src, alu_src_b, alu_op, reg_dst;
    logic [2:0] state_o;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cyc_cnt, ret_cnt;
`endif

    multicycle_ctrl #(.OPW(6), .FUNCW(6), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .op(op), .func(func), .alu_zero(alu_zero),
        .stall(stall), .imem_req(imem_req), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_we(reg_we), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .link(link), .illegal(illegal),
        .instr_done(instr_done),
`ifdef MC_PERF_CNT_EN
        .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt),
`endif
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    int   n_chk = 0, n_fail = 0;
    int   n_cyc = 0, n_ret = 0;
    ctl_t e;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Compare the whole output bundle against e / st, then advance one cycle.
    task automatic cyc(input string tag, input state_t st);
        ctl_t o;
        #1;
        o.imem_req = imem_req;   o.dmem_req = dmem_req;   o.dmem_we = dmem_we;
        o.ir_we = ir_we;         o.pc_we = pc_we;         o.pc_src = pc_src;
        o.alu_src_b = alu_src_b; o.alu_op = alu_op;       o.reg_we = reg_we;
        o.reg_dst = reg_dst;     o.mem_to_reg = mem_to_reg; o.link = link;
        o.illegal = illegal;     o.instr_done = instr_done;
        chk(tag, 32'({o, state_o}), 32'({e, st}));
        if (!reset) n_cyc++;
        if (e.instr_done) n_ret++;
        @(negedge clk);
        e = '0;
    endtask

    // FETCH with 'waits' wait states, then present the new IR fields.
    task automatic fetch(input string tag, input int waits, input logic [5:0] o_v, input logic [5:0] f_v);
        for (int w = 0; w <= waits; w++) begin
            imem_ack   = (w == waits);
            e          = '0;
            e.imem_req = 1'b1;
            e.ir_we    = imem_ack;
            e.pc_we    = imem_ack;
            cyc(tag, S_FETCH);
        end
        imem_ack = 1'b0;
        op       = o_v;
        func     = f_v;
    endtask

    initial begin
        e = '0;
        @(negedge clk);
        cyc("reset", S_FETCH);        // reset held: all outputs 0
        reset = 1'b0;

        // stall during FETCH with ack present: no strobes, no advance
        stall = 1'b1; imem_ack = 1'b1;
        e.imem_req = 1'b1; cyc("fetch_stall", S_FETCH);
        stall = 1'b0;

        // LW, 2 imem waits, 3 dmem waits
        fetch("lw_f", 2, OP_LW, 6'h0);
        cyc("lw_d", S_DECODE);
        e.alu_src_b = ALUB_SIMM; cyc("lw_e", S_EXEC);
        for (int i = 0; i < 3; i++) begin
            e.dmem_req = 1'b1; cyc("lw_m_wait", S_MEM);
        end
        dmem_ack = 1'b1;
        e.dmem_req = 1'b1; cyc("lw_m_ack", S_MEM);
        dmem_ack = 1'b0;
        e.reg_we = 1'b1; e.mem_to_reg = 1'b1; e.instr_done = 1'b1;
        cyc("lw_wb", S_WB);

        // BEQ taken
        fetch("beq_f", 0, OP_BEQ, 6'h0); alu_zero = 1'b1;
        cyc("beq_d", S_DECODE);
        e.alu_op = ALU_SUB; e.pc_src = PC_SRC_BR; e.pc_we = 1'b1; e.instr_done = 1'b1;
        cyc("beq_e_taken", S_EXEC);

        // BNE with zero: not taken
        fetch("bne_f", 0, OP_BNE, 6'h0);
        cyc("bne_d", S_DECODE);
        e.alu_op = ALU_SUB; e.pc_src = PC_SRC_BR; e.instr_done = 1'b1;
        cyc("bne_e_nt", S_EXEC);

        // BEQ with non-zero: not taken
        fetch("beq2_f", 0, OP_BEQ, 6'h0); alu_zero = 1'b0;
        cyc("beq2_d", S_DECODE);
        e.alu_op = ALU_SUB; e.pc_src = PC_SRC_BR; e.instr_done = 1'b1;
        cyc("beq2_e_nt", S_EXEC);

        // JAL
        fetch("jal_f", 0, OP_JAL, 6'h0);
        e.pc_we = 1'b1; e.pc_src = PC_SRC_JMP; e.reg_we = 1'b1; e.reg_dst = DST_R31;
        e.link = 1'b1; e.instr_done = 1'b1;
        cyc("jal_d", S_DECODE);

        // J
        fetch("j_f", 0, OP_J, 6'h0);
        e.pc_we = 1'b1; e.pc_src = PC_SRC_JMP; e.instr_done = 1'b1;
        cyc("j_d", S_DECODE);

        // NOP (R with func 0)
        fetch("nop_f", 0, OP_R, FUNC_NOP);
        e.instr_done = 1'b1; cyc("nop_d", S_DECODE);

        // illegal opcode
        fetch("ill_f", 0, 6'h3F, 6'h0);
        e.illegal = 1'b1; cyc("ill_d", S_DECODE);

        // ADDI
        fetch("addi_f", 0, OP_ADDI, 6'h0);
        cyc("addi_d", S_DECODE);
        e.alu_src_b = ALUB_SIMM; e.alu_op = ALU_ADD; cyc("addi_e", S_EXEC);
        e.reg_we = 1'b1; e.reg_dst = DST_RT; e.instr_done = 1'b1; cyc("addi_wb", S_WB);

        // ORI
        fetch("ori_f", 0, OP_ORI, 6'h0);
        cyc("ori_d", S_DECODE);
        e.alu_src_b = ALUB_ZIMM; e.alu_op = ALU_OR; cyc("ori_e", S_EXEC);
        e.reg_we = 1'b1; e.reg_dst = DST_RT; e.instr_done = 1'b1; cyc("ori_wb", S_WB);

        // R-type ADD
        fetch("radd_f", 0, OP_R, 6'h20);
        cyc("radd_d", S_DECODE);
        e.alu_op = ALU_FUNC; cyc("radd_e", S_EXEC);
        e.reg_we = 1'b1; e.reg_dst = DST_RD; e.instr_done = 1'b1; cyc("radd_wb", S_WB);

        // SW with a 5-cycle stall in MEM (ack present but ignored), zero-wait ack
        fetch("sw_f", 0, OP_SW, 6'h0);
        cyc("sw_d", S_DECODE);
        e.alu_src_b = ALUB_SIMM; cyc("sw_e", S_EXEC);
        stall = 1'b1; dmem_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            e.dmem_req = 1'b1; e.dmem_we = 1'b1; cyc("sw_m_stall", S_MEM);
        end
        stall = 1'b0;
        e.dmem_req = 1'b1; e.dmem_we = 1'b1; e.instr_done = 1'b1;
        cyc("sw_m_ack", S_MEM);
        dmem_ack = 1'b0;

        // R-type ADD aborted by reset in WB
        fetch("rst_f", 0, OP_R, 6'h21);
        cyc("rst_d", S_DECODE);
        e.alu_op = ALU_FUNC; cyc("rst_e", S_EXEC);
`ifdef MC_PERF_CNT_EN
        #1;
        chk("cyc_cnt", cyc_cnt, 32'(n_cyc));
        chk("ret_cnt", ret_cnt, 32'(n_ret));
`endif
        reset = 1'b1;
        cyc("rst_wb", S_FETCH);       // all outputs 0, reg_we suppressed
`ifdef MC_PERF_CNT_EN
        #1;
        chk("cyc_cnt_rst", cyc_cnt, 32'd0);
        chk("ret_cnt_rst", ret_cnt, 32'd0);
`endif
        reset = 1'b0;
        e.imem_req = 1'b1; cyc("post_rst", S_FETCH);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
